// File: rtl/flash_port_arbiter.sv
// rtl/flash_port_arbiter.sv - two-port asynchronous flash read arbiter; FLASH_ARB_ROUND_ROBIN_EN selects round-robin ties
module flash_port_arbiter #(
    parameter int P_WAIT_CYCLES = 4
) (
    input  logic        I_CLK,
    input  logic        I_RESET_L,
    input  logic        I_A_REQ,
    input  logic [23:0] I_A_ADDR,
    output logic        O_A_ACK,
    output logic [15:0] O_A_DATA,
    input  logic        I_B_REQ,
    input  logic [23:0] I_B_ADDR,
    output logic        O_B_ACK,
    output logic [15:0] O_B_DATA,
    input  logic [15:0] I_FLASH_DATA,
    output logic [23:0] O_FLASH_ADDR,
    output logic        O_FLASH_CE_L,
    output logic        O_FLASH_OE_L,
    output logic        O_ADDR_VALID_L,
    output logic        O_FLASH_WE_L,
    output logic        O_FLASH_CLK,
    output logic        O_BUSY
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_RECOVER = 2'd2;

    localparam logic [7:0] WAIT_INIT = 8'(P_WAIT_CYCLES - 1);

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic       winner_b;
    logic       grant_b;

`ifdef FLASH_ARB_ROUND_ROBIN_EN
    logic       last_b;

    // On a tie the port that did not win the previous grant goes first.
    always_comb begin
        grant_b = 1'b0;
        if (I_A_REQ && I_B_REQ) begin
            grant_b = ~last_b;
        end else begin
            grant_b = I_B_REQ;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RESET_L) begin
            last_b <= 1'b1;
        end else if (state == S_IDLE && (I_A_REQ || I_B_REQ)) begin
            last_b <= grant_b;
        end
    end
`else
    always_comb begin
        grant_b = ~I_A_REQ;
    end
`endif

    assign O_FLASH_WE_L = 1'b1;
    assign O_FLASH_CLK  = 1'b1;
    assign O_BUSY       = (state != S_IDLE);

    always_ff @(posedge I_CLK) begin
        if (!I_RESET_L) begin
            state          <= S_IDLE;
            wait_cnt       <= 8'd0;
            winner_b       <= 1'b0;
            O_A_ACK        <= 1'b0;
            O_B_ACK        <= 1'b0;
            O_A_DATA       <= 16'h0000;
            O_B_DATA       <= 16'h0000;
            O_FLASH_ADDR   <= 24'h000000;
            O_FLASH_CE_L   <= 1'b1;
            O_FLASH_OE_L   <= 1'b1;
            O_ADDR_VALID_L <= 1'b1;
        end else begin
            O_A_ACK <= 1'b0;
            O_B_ACK <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (I_A_REQ || I_B_REQ) begin
                        winner_b       <= grant_b;
                        O_FLASH_ADDR   <= grant_b ? I_B_ADDR : I_A_ADDR;
                        wait_cnt       <= WAIT_INIT;
                        O_FLASH_CE_L   <= 1'b0;
                        O_FLASH_OE_L   <= 1'b0;
                        O_ADDR_VALID_L <= 1'b0;
                        state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        if (winner_b) begin
                            O_B_DATA <= I_FLASH_DATA;
                            O_B_ACK  <= 1'b1;
                        end else begin
                            O_A_DATA <= I_FLASH_DATA;
                            O_A_ACK  <= 1'b1;
                        end
                        // Controls release together with the ack; address holds through recovery.
                        O_FLASH_CE_L   <= 1'b1;
                        O_FLASH_OE_L   <= 1'b1;
                        O_ADDR_VALID_L <= 1'b1;
                        state          <= S_RECOVER;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                S_RECOVER: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_port_arbiter.sv
// tb/tb_flash_port_arbiter.sv - directed self-checking bench for flash_port_arbiter
module tb_flash_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        a_req = 1'b0, b_req = 1'b0;
    logic [23:0] a_addr = '0, b_addr = '0;
    logic        a_ack, b_ack;
    logic [15:0] a_data, b_data;
    logic [15:0] flash_data;
    logic [23:0] flash_addr;
    logic        ce_l, oe_l, av_l, we_l, fclk, busy;

    logic        a_req2 = 1'b0, b_req2 = 1'b0;
    logic [23:0] a_addr2 = '0, b_addr2 = '0;
    logic        a_ack2, b_ack2;
    logic [15:0] a_data2, b_data2;
    logic [15:0] flash_data2;
    logic [23:0] flash_addr2;
    logic        ce_l2, oe_l2, av_l2, we_l2, fclk2, busy2;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] flash_word(input logic [23:0] addr);
        if (addr == 24'h008123) return 16'hBEEF;
        return (addr[15:0] ^ 16'hC3A5) + {8'h00, addr[23:16]};
    endfunction

    assign flash_data  = flash_word(flash_addr);
    assign flash_data2 = flash_word(flash_addr2);

    flash_port_arbiter #(.P_WAIT_CYCLES(4)) dut (
        .I_CLK(clk), .I_RESET_L(rst_l),
        .I_A_REQ(a_req), .I_A_ADDR(a_addr), .O_A_ACK(a_ack), .O_A_DATA(a_data),
        .I_B_REQ(b_req), .I_B_ADDR(b_addr), .O_B_ACK(b_ack), .O_B_DATA(b_data),
        .I_FLASH_DATA(flash_data), .O_FLASH_ADDR(flash_addr),
        .O_FLASH_CE_L(ce_l), .O_FLASH_OE_L(oe_l), .O_ADDR_VALID_L(av_l),
        .O_FLASH_WE_L(we_l), .O_FLASH_CLK(fclk), .O_BUSY(busy)
    );

    flash_port_arbiter #(.P_WAIT_CYCLES(1)) dut1 (
        .I_CLK(clk), .I_RESET_L(rst_l),
        .I_A_REQ(a_req2), .I_A_ADDR(a_addr2), .O_A_ACK(a_ack2), .O_A_DATA(a_data2),
        .I_B_REQ(b_req2), .I_B_ADDR(b_addr2), .O_B_ACK(b_ack2), .O_B_DATA(b_data2),
        .I_FLASH_DATA(flash_data2), .O_FLASH_ADDR(flash_addr2),
        .O_FLASH_CE_L(ce_l2), .O_FLASH_OE_L(oe_l2), .O_ADDR_VALID_L(av_l2),
        .O_FLASH_WE_L(we_l2), .O_FLASH_CLK(fclk2), .O_BUSY(busy2)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic reset_pulse();
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
    endtask

    initial begin
        int gap;
        logic got_a, got_b;

        // Power-on reset state
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_ce", ce_l, 1);
        chk("rst_oe", oe_l, 1);
        chk("rst_av", av_l, 1);
        chk("rst_acks", {a_ack, b_ack}, 0);
        chk("rst_data", {a_data, b_data}, 0);
        chk("rst_addr", flash_addr, 0);
        chk("we_clk", {we_l, fclk}, 2'b11);
        rst_l = 1'b1;

        // Reset during WAIT aborts; held request is serviced afterwards
        a_req = 1'b1; a_addr = 24'h000300;
        tick();
        chk("r4_busy_c1", busy, 1);
        chk("r4_ce_c1", ce_l, 0);
        tick();
        rst_l = 1'b0;
        tick();
        chk("r4_busy_abort", busy, 0);
        chk("r4_ctl_abort", {ce_l, oe_l, av_l}, 3'b111);
        chk("r4_ack_abort", a_ack, 0);
        chk("r4_data_abort", a_data, 16'h0000);
        rst_l = 1'b1;
        tick(4);
        chk("r4_ack_early", a_ack, 0);
        tick();
        chk("r4_ack", a_ack, 1);
        chk("r4_data", a_data, 16'hC0A5);
        a_req = 1'b0;
        tick();
        chk("r4_idle", busy, 0);

        // Single A read with P_WAIT_CYCLES=4
        a_req = 1'b1; a_addr = 24'h008123;
        tick();
        chk("t1_addr_c1", flash_addr, 24'h008123);
        chk("t1_ctl_c1", {ce_l, oe_l, av_l}, 3'b000);
        chk("t1_busy_c1", busy, 1);
        tick(3);
        chk("t1_ack_c4", a_ack, 0);
        tick();
        chk("t1_ack_c5", a_ack, 1);
        chk("t1_data", a_data, 16'hBEEF);
        chk("t1_ce_c5", ce_l, 1);
        chk("t1_addr_c5", flash_addr, 24'h008123);
        a_req = 1'b0;
        tick();
        chk("t1_busy_c6", busy, 0);
        chk("t1_ack_c6", a_ack, 0);

        // Address change after grant is ignored
        reset_pulse();
        a_req = 1'b1; a_addr = 24'h000100;
        tick(2);
        a_addr = 24'h000200;
        tick();
        chk("t6_addr_c3", flash_addr, 24'h000100);
        tick(2);
        chk("t6_ack", a_ack, 1);
        chk("t6_data", a_data, 16'hC2A5);
        a_req = 1'b0;
        tick();

        // Simultaneous requests: A first, B six cycles later
        reset_pulse();
        a_req = 1'b1; a_addr = 24'h000100;
        b_req = 1'b1; b_addr = 24'h208000;
        tick(5);
        chk("t2_a_ack", {a_ack, b_ack}, 2'b10);
        chk("t2_a_data", a_data, 16'hC2A5);
        chk("t2_b_data_hold", b_data, 16'h0000);
        a_req = 1'b0;
        tick();
        chk("t2_c6_ack", {a_ack, b_ack}, 2'b00);
        tick();
        chk("t2_b_addr", flash_addr, 24'h208000);
        tick(4);
        chk("t2_b_ack", {a_ack, b_ack}, 2'b01);
        chk("t2_b_data", b_data, 16'h43C5);

        // Both held continuously: fixed priority starves B, round-robin alternates
        a_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            gap = 0; got_a = 1'b0; got_b = 1'b0;
            for (int c = 0; c < 10; c++) begin
                tick();
                gap++;
                if (a_ack || b_ack) begin
                    got_a = a_ack; got_b = b_ack;
                    break;
                end
            end
            chk("t3_gap", gap, 6);
`ifdef FLASH_ARB_ROUND_ROBIN_EN
            chk("t3_ack_pair", {got_a, got_b}, (k % 2 == 0) ? 2'b10 : 2'b01);
`else
            chk("t3_ack_pair", {got_a, got_b}, 2'b10);
`endif
        end
        a_req = 1'b0; b_req = 1'b0;
        tick(2);
        chk("t3_idle", busy, 0);

        // P_WAIT_CYCLES=1, back-to-back B requests
        b_req2 = 1'b1; b_addr2 = 24'h000000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_noack", b_ack2, 0);
            tick();
            chk("t5_ack", b_ack2, 1);
            chk("t5_data", b_data2, (k == 0) ? 16'hC3A5 : (k == 1) ? 16'hC3A4 : 16'hC3A7);
            b_addr2 = 24'(k + 1);
            if (k == 2) b_req2 = 1'b0;
            tick();
            chk("t5_idle_ack", b_ack2, 0);
        end
        tick();
        chk("t5_busy_end", busy2, 0);
        chk("t5_a_quiet", a_data2, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
